// File: rtl/conv_encoder_serial.sv
// Rate-1/N, constraint-length-K feed-forward convolutional encoder that serialises
// each coded symbol onto a valid/ready stream, with an optional zero tail per frame.
module conv_encoder_serial #(
    parameter int              K       = 3,
    parameter int              N       = 2,
    parameter logic [N*K-1:0]  G       = {3'b101, 3'b111},
    parameter int              TAIL_EN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_data,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last,
    output logic busy
);

    localparam int   IW      = (N > 1) ? $clog2(N) : 1;
    localparam int   TW      = $clog2(K);
    localparam logic TAIL_ON = (TAIL_EN != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [K-2:0]    sr, sr_nx;
    logic [N-1:0]    coded, coded_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic [TW-1:0]   tail_cnt, tail_cnt_nx;
    logic            last_pend, last_pend_nx;
    logic            last_idx;
    logic            fire_out;
    logic            accept;

    // Tap vector puts the current bit at K-1 and the oldest past bit at 0.
    function automatic logic [N-1:0] encode(input logic d, input logic [K-2:0] s);
        logic [K-1:0] taps;
        logic [N-1:0] c;
        taps[K-1] = d;
        for (int i = 0; i < K - 1; i++) begin
            taps[K-2-i] = s[i];
        end
        for (int j = 0; j < N; j++) begin
            c[j] = ^(G[j*K +: K] & taps);
        end
        return c;
    endfunction

    function automatic logic [K-2:0] shift_in(input logic d, input logic [K-2:0] s);
        logic [K-2:0] r;
        r    = s << 1'b1;
        r[0] = d;
        return r;
    endfunction

    assign last_idx  = (idx == IW'(N - 1));
    assign out_valid = (state != IDLE);
    assign busy      = (state != IDLE);
    assign fire_out  = out_valid & out_ready;
    assign out_bit   = coded[idx];
    assign out_last  = out_valid & last_idx &
                       (((state == TAIL) & (tail_cnt == TW'(0))) |
                        ((state == EMIT) & last_pend & ~TAIL_ON));
    // Back-to-back acceptance only when the final coded bit of a non-tail symbol leaves now.
    assign in_ready  = (state == IDLE) |
                       ((state == EMIT) & last_idx & out_ready & ~(last_pend & TAIL_ON));
    assign accept    = in_valid & in_ready;

    // Next-state, symbol loading and serialiser index control.
    always_comb begin
        state_nx     = state;
        sr_nx        = sr;
        coded_nx     = coded;
        idx_nx       = idx;
        tail_cnt_nx  = tail_cnt;
        last_pend_nx = last_pend;
        case (state)
            IDLE: begin
                if (accept) begin
                    coded_nx     = encode(in_data, sr);
                    sr_nx        = shift_in(in_data, sr);
                    idx_nx       = IW'(0);
                    last_pend_nx = in_last;
                    state_nx     = EMIT;
                end else begin
                    state_nx     = IDLE;
                end
            end
            EMIT: begin
                if (fire_out && last_idx) begin
                    idx_nx = IW'(0);
                    if (last_pend && TAIL_ON) begin
                        coded_nx    = encode(1'b0, sr);
                        sr_nx       = shift_in(1'b0, sr);
                        tail_cnt_nx = TW'(K - 2);
                        state_nx    = TAIL;
                    end else if (accept) begin
                        coded_nx     = encode(in_data, sr);
                        sr_nx        = shift_in(in_data, sr);
                        last_pend_nx = in_last;
                        state_nx     = EMIT;
                    end else begin
                        last_pend_nx = 1'b0;
                        state_nx     = IDLE;
                    end
                end else if (fire_out) begin
                    idx_nx = idx + IW'(1);
                end else begin
                    idx_nx = idx;
                end
            end
            TAIL: begin
                if (fire_out && last_idx) begin
                    idx_nx = IW'(0);
                    if (tail_cnt == TW'(0)) begin
                        last_pend_nx = 1'b0;
                        state_nx     = IDLE;
                    end else begin
                        coded_nx    = encode(1'b0, sr);
                        sr_nx       = shift_in(1'b0, sr);
                        tail_cnt_nx = tail_cnt - TW'(1);
                    end
                end else if (fire_out) begin
                    idx_nx = idx + IW'(1);
                end else begin
                    idx_nx = idx;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            coded     <= '0;
            idx       <= '0;
            tail_cnt  <= '0;
            last_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            coded     <= coded_nx;
            idx       <= idx_nx;
            tail_cnt  <= tail_cnt_nx;
            last_pend <= last_pend_nx;
        end
    end

endmodule

// File: tb/tb_conv_encoder_serial.sv
// Scoreboard bench: three encoder configurations share one stimulus port selected by sel.
module tb_conv_encoder_serial;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_data, in_last, out_ready;
    int   sel;
    logic bp_en;

    logic a_in_ready, a_out_valid, a_out_bit, a_out_last, a_busy;
    logic b_in_ready, b_out_valid, b_out_bit, b_out_last, b_busy;
    logic c_in_ready, c_out_valid, c_out_bit, c_out_last, c_busy;
    logic a_in_valid, b_in_valid, c_in_valid;
    logic m_ir, m_ov, m_ob, m_ol, m_busy;

    typedef struct packed {
        logic b;
        logic l;
    } exp_t;
    exp_t q[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   pops = 0;
    int   bubbles = 0;
    int   pos = 0;
    logic no_rdy = 1'b0;
    logic stalled_prev = 1'b0;
    logic held_bit, held_last;
    logic [2:0] msr;
    logic [2:0] cc;

    always #5 clk = ~clk;

    assign a_in_valid = in_valid && (sel == 0);
    assign b_in_valid = in_valid && (sel == 1);
    assign c_in_valid = in_valid && (sel == 2);
    assign m_ir   = (sel == 0) ? a_in_ready  : (sel == 1) ? b_in_ready  : c_in_ready;
    assign m_ov   = (sel == 0) ? a_out_valid : (sel == 1) ? b_out_valid : c_out_valid;
    assign m_ob   = (sel == 0) ? a_out_bit   : (sel == 1) ? b_out_bit   : c_out_bit;
    assign m_ol   = (sel == 0) ? a_out_last  : (sel == 1) ? b_out_last  : c_out_last;
    assign m_busy = (sel == 0) ? a_busy      : (sel == 1) ? b_busy      : c_busy;

    conv_encoder_serial #(.K(3), .N(2), .G(6'b101_111), .TAIL_EN(0)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_bit(a_out_bit), .out_last(a_out_last), .busy(a_busy));

    conv_encoder_serial #(.K(3), .N(2), .G(6'b101_111), .TAIL_EN(1)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_bit(b_out_bit), .out_last(b_out_last), .busy(b_busy));

    conv_encoder_serial #(.K(4), .N(3), .G(12'b1011_1101_1111), .TAIL_EN(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_bit(c_out_bit), .out_last(c_out_last), .busy(c_busy));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Generators written out from the polynomials 1111, 1101, 1011 (d, s0, s1, s2 taps).
    function automatic logic [2:0] ref_k4(input logic d, input logic [2:0] s);
        ref_k4[0] = d ^ s[0] ^ s[1] ^ s[2];
        ref_k4[1] = d ^ s[0] ^ s[2];
        ref_k4[2] = d ^ s[1] ^ s[2];
    endfunction

    task automatic push(input logic b, input logic l);
        exp_t e;
        e.b = b;
        e.l = l;
        q.push_back(e);
    endtask

    task automatic send(input logic d, input logic l);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = m_ir;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 8'd0, 8'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) chk("drain_timeout", 8'(q.size()), 8'd0);
        @(posedge clk);
        #1;
    endtask

    // Downstream readiness: constant high, or pseudo-random when backpressure is enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        int   n_cur;
        n_cur = (sel == 2) ? 3 : 2;
        if (reset) begin
            if (!m_ov && q.size() != 0) bubbles++;
            if (in_valid && m_ov) begin
                exp_rdy = (pos == n_cur - 1) && out_ready && !no_rdy;
                chk("in_ready_emit", 8'(m_ir), 8'(exp_rdy));
            end
            if (no_rdy) chk("in_ready_tail", 8'(m_ir), 8'd0);
            if (stalled_prev && m_ov) begin
                chk("stall_bit", 8'(m_ob), 8'(held_bit));
                chk("stall_last", 8'(m_ol), 8'(held_last));
            end
            if (m_ov && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 8'd1, 8'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_bit", 8'(m_ob), 8'(e.b));
                    chk("out_last", 8'(m_ol), 8'(e.l));
                    if (e.l) no_rdy = 1'b0;
                end
                pops++;
                pos = (pos == n_cur - 1) ? 0 : pos + 1;
            end
            stalled_prev = m_ov && !out_ready;
            held_bit     = m_ob;
            held_last    = m_ol;
        end else begin
            pos          = 0;
            stalled_prev = 1'b0;
        end
    end

    task automatic run_b();
        send(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
        send(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0);
        send(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
        send(1'b1, 1'b1); no_rdy = 1'b1;
        push(1'b0, 1'b0); push(1'b1, 1'b0);
        push(1'b0, 1'b0); push(1'b1, 1'b0);
        push(1'b1, 1'b0); push(1'b1, 1'b1);
        drain();
    endtask

    initial begin
        int p0;
        logic d;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 1'b0;
        in_last  = 1'b0;
        sel      = 0;
        bp_en    = 1'b0;

        // Reset held with random inputs: every configuration stays quiet.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            for (int s = 0; s < 3; s++) begin
                sel = s;
                #1;
                chk("rst_out_valid", 8'(m_ov), 8'd0);
                chk("rst_out_last", 8'(m_ol), 8'd0);
                chk("rst_busy", 8'(m_busy), 8'd0);
                chk("rst_out_bit", 8'(m_ob), 8'd0);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_in_ready", 8'(m_ir), 8'd1);
        end

        // No-tail encoder, back-to-back bits 1,0,1,1.
        sel = 0;
        @(posedge clk);
        #1;
        bubbles = 0;
        send(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
        send(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0);
        send(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
        send(1'b1, 1'b1); push(1'b0, 1'b0); push(1'b1, 1'b1);
        drain();
        chk("a_no_bubbles", 8'(bubbles), 8'd0);

        // Tail-enabled encoder, free-flowing then under backpressure.
        sel = 1;
        bubbles = 0;
        run_b();
        chk("b_no_bubbles", 8'(bubbles), 8'd0);
        bp_en = 1'b1;
        run_b();
        bp_en = 1'b0;
        chk("b_bp_no_bubbles", 8'(bubbles), 8'd0);
        @(posedge clk);
        #1;

        // Reset after three coded bits; the next frame must start from a clear register.
        p0 = pops;
        send(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
        send(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0);
        for (int i = 0; i < 50 && pops < p0 + 3; i++) @(negedge clk);
        chk("mid_pops", 8'(pops - p0), 8'd3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", 8'(m_ov), 8'd0);
        chk("mid_rst_busy", 8'(m_busy), 8'd0);
        chk("mid_rst_last", 8'(m_ol), 8'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 1'b1); no_rdy = 1'b1;
        push(1'b1, 1'b0); push(1'b1, 1'b0);
        push(1'b1, 1'b0); push(1'b0, 1'b0);
        push(1'b1, 1'b0); push(1'b1, 1'b1);
        drain();

        // K=4, N=3 configuration against the reference generators, random frames.
        sel = 2;
        for (int f = 0; f < 4; f++) begin
            bp_en = (f >= 2);
            msr = 3'b000;
            for (int i = 0; i < 64; i++) begin
                d = 1'($urandom_range(0, 1));
                send(d, (i == 63));
                if (i == 63) no_rdy = 1'b1;
                cc = ref_k4(d, msr);
                msr = {msr[1:0], d};
                push(cc[0], 1'b0); push(cc[1], 1'b0); push(cc[2], 1'b0);
            end
            for (int t = 0; t < 3; t++) begin
                cc = ref_k4(1'b0, msr);
                msr = {msr[1:0], 1'b0};
                push(cc[0], 1'b0); push(cc[1], 1'b0); push(cc[2], (t == 2));
            end
            if (f % 2 == 0) begin
                drain();
                chk("c_sr_zero", 8'(u_c.sr), 8'd0);
            end
        end
        drain();
        chk("c_sr_zero_end", 8'(u_c.sr), 8'd0);
        bp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_encoder_serial.md
Name: conv_encoder_serial

Overview:
- Parametrised rate-1/N, constraint-length-K feed-forward convolutional encoder with an integrated parallel-to-serial output stage.
- Accepts one information bit per valid/ready handshake and emits the N coded bits, one per cycle, on a valid/ready serial stream.
- Optionally appends K-1 zero tail bits at frame end to return the encoder to the all-zero state.
- Sits between the bit source and the modulator, replacing the fixed K=3, rate-1/2 two-clock encoder with a single-clock, backpressure-aware block.

Parameters:
- K, 3, constraint length; shift register holds K-1 past bits; legal 2..9.
- N, 2, coded bits per information bit; legal 2..4.
- G, {3'b101,3'b111}, packed generator polynomials, N*K bits. Polynomial j is G[j*K +: K]. Bit K-1 taps the current input, bit K-2 taps sr[0] (newest past bit), bit 0 taps sr[K-2] (oldest).
- TAIL_EN, 1, 1 = append K-1 zero tail bits after in_last; 0 = no tail, state carries across frames.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  information bit valid
- in_ready  output  1  encoder can accept an information bit this cycle
- in_data  input  1  information bit
- in_last  input  1  qualifies in_data as the last bit of the frame
- out_valid  output  1  out_bit valid
- out_ready  input  1  downstream accepts out_bit this cycle
- out_bit  output  1  serial coded bit
- out_last  output  1  final coded bit of the frame (tail included when TAIL_EN=1)
- busy  output  1  high while in EMIT or TAIL

Behaviour:
- Reset (async, active-low) clears all state:
  - sr = 0, idx = 0, tail_cnt = 0, state = IDLE.
  - out_valid = 0, out_bit = 0, out_last = 0, busy = 0.
  - in_ready = 1 once reset is released.
- Coding rule: on acceptance of bit d, capture coded[j] = XOR-reduce(G_j & {d, sr}) for all j into an N-bit register. Then sr <= {sr[K-3:0], d}, with sr[0] = d.
- Default parameters give coded[0] = d^sr[0]^sr[1] and coded[1] = d^sr[1].
- Serial order: coded[0] first, coded[N-1] last. out_bit = coded[idx].
- FSM states: IDLE, EMIT, TAIL.
  - IDLE: in_ready = 1, out_valid = 0. Input accept (in_valid & in_ready) loads coded, sets idx = 0, latches last_pend = in_last, and goes to EMIT.
  - EMIT: out_valid = 1. Each out_valid & out_ready advances idx. On the handshake with idx == N-1:
    - If last_pend = 1 and TAIL_EN = 1: inject d = 0 internally, tail_cnt = K-2, go to TAIL.
    - Else if in_valid is high that cycle: accept the next bit back-to-back (zero-bubble; in_ready is combinationally high in this condition) and stay in EMIT with idx = 0.
    - Else go to IDLE.
  - TAIL: same emission as EMIT with in_ready = 0. On the handshake with idx == N-1: if tail_cnt == 0, go to IDLE; else inject another 0 and decrement tail_cnt.
- Latency: first coded bit is valid the cycle after input accept. Sustained throughput with out_ready = 1 is N output cycles per information bit, with no idle cycles.
- Backpressure: while out_valid = 1 and out_ready = 0, out_bit, out_last and idx hold stable, and no input is accepted.
- out_last:
  - Asserted only on idx == N-1 of the last emitted symbol of the frame: the last tail symbol when TAIL_EN = 1, otherwise the in_last symbol.
  - When TAIL_EN = 1, sr == 0 after out_last is accepted.
- in_last with TAIL_EN = 0: out_last is marked, sr is not cleared.
- in_valid while in TAIL is ignored; it is held by the upstream handshake.
- Reset asserted mid-frame: outputs drop to their reset values immediately and the partial frame is discarded. The first frame after reset starts from sr = 0.

Test Plan:
- Reset check: assert reset with random inputs -> out_valid = 0, out_last = 0, busy = 0, and in_ready = 1 after release.
- Default params, TAIL_EN = 0, out_ready = 1, bits 1,0,1,1 back-to-back -> out_bit stream 1,1, 1,0, 0,0, 0,1 over 8 consecutive cycles with no gaps. in_ready is high on the idx = 1 cycles.
- Same stimulus with TAIL_EN = 1 and in_last on the 4th bit -> 12 bits: 11 10 00 01 01 11. out_last only on the 12th bit, and in_ready = 0 during the tail.
- Backpressure: toggle out_ready pseudo-randomly during the previous scenario -> identical accepted bit sequence, and out_bit is stable on every stalled cycle.
- Reset mid-frame after 3 coded bits, then send 1 -> first output pair is 1,1, proving sr was cleared.
- Parameter sweep K=4, N=3, G = {4'b1011, 4'b1101, 4'b1111}, random 64-bit frames -> output matches a behavioural reference model bit-exact, and sr == 0 after each out_last.
